seg7_scan_driver: RTL and testbench

Parametrised multi-digit 7-segment display driver, the next generation of the team's single-digit encoder. It accepts a binary value through a load handshake and converts it to BCD sequentially (shift-and-add-3) or uses it as raw hex nibbles. It holds the digits in a display buffer and time-multiplexes them onto one shared segment bus with a one-hot digit select. It sits between datapath result registers and the board's common-cathode display.

---
 rtl/seg7_scan_driver.sv | 260 ++++++++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
//   Multi-digit 7-segment display driver. A binary value is captured on load
//   and either converted to BCD (double-dabble, one bit per cycle) or taken
//   as raw hex nibbles. The result lands in a display buffer that is scanned
//   one digit at a time onto a shared segment bus for a common-cathode panel.
//
// Ports
//   clk        system clock
//   nrst       asynchronous active-low reset
//   load       capture request for value_in (pulse or level)
//   value_in   binary value to display
//   hex_mode   sampled with load: 1 = hex nibbles, 0 = decimal
//   blank_en   live: 1 = blank leading zero digits
//   busy       conversion in progress, load ignored while high
//   done       one-cycle pulse on the cycle the display buffer updates
//   sv_seg     segments {g,f,e,d,c,b,a}, active high, registered
//   digit_sel  one-hot digit enable (bit 0 = least significant), registered
// ----------------------------------------------------------------------------
module seg7_scan_driver #(
   parameter int NUM_DIGITS = 4,
   parameter int BIN_W      = 16,
   parameter int SCAN_DIV   = 1000
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  load,
   input  logic [BIN_W-1:0]      value_in,
   input  logic                  hex_mode,
   input  logic                  blank_en,
   output logic                  busy,
   output logic                  done,
   output logic [6:0]            sv_seg,
   output logic [NUM_DIGITS-1:0] digit_sel
);

   localparam int DW     = 4 * NUM_DIGITS;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W  = $clog2(SCAN_DIV);
   localparam int STEP_W = $clog2(BIN_W + 1);

   // 10^n as a 64-bit constant, used for the decimal overflow threshold
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

   localparam logic [63:0] DEC_LIMIT = pow10(NUM_DIGITS);

   // Nibble to segment pattern {g,f,e,d,c,b,a}
   function automatic logic [6:0] seg7_enc(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'b0111111;
         4'h1:    s = 7'b0000110;
         4'h2:    s = 7'b1011011;
         4'h3:    s = 7'b1001111;
         4'h4:    s = 7'b1100110;
         4'h5:    s = 7'b1101101;
         4'h6:    s = 7'b1111101;
         4'h7:    s = 7'b0000111;
         4'h8:    s = 7'b1111111;
         4'h9:    s = 7'b1101111;
         4'ha:    s = 7'b1110111;
         4'hb:    s = 7'b1111100;
         4'hc:    s = 7'b0111001;
         4'hd:    s = 7'b1011110;
         4'he:    s = 7'b1111001;
         4'hf:    s = 7'b1110001;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CONV   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t                       state_r;
   state_t                       state_s;
   logic [BIN_W-1:0]             shift_r;
   logic [DW-1:0]                bcd_r;
   logic [DW-1:0]                dabble_s;
   logic [STEP_W-1:0]            step_r;
   logic                         ovf_r;
   logic [NUM_DIGITS-1:0][3:0]   buf_r;
   logic                         dash_r;
   logic                         busy_r;
   logic                         done_r;
   logic [CNT_W-1:0]             cnt_r;
   logic [IDX_W-1:0]             idx_r;
   logic [NUM_DIGITS-1:0]        upper_zero_s;
   logic [6:0]                   seg_s;
   logic [NUM_DIGITS-1:0]        digit_sel_s;
   logic [6:0]                   sv_seg_r;
   logic [NUM_DIGITS-1:0]        digit_sel_r;
   logic [63:0]                  val_ext_s;
   logic [DW-1:0]                hex_ext_s;

   assign val_ext_s = 64'(value_in);
   assign hex_ext_s = DW'(value_in);

   // FSM state register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (load) begin
               state_s = hex_mode ? S_COMMIT : S_CONV;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_CONV: begin
            if (step_r == STEP_W'(BIN_W - 1)) begin
               state_s = S_COMMIT;
            end else begin
               state_s = S_CONV;
            end
         end
         S_COMMIT: state_s = S_IDLE;
         default:  state_s = S_IDLE;
      endcase
   end

   // Double-dabble adjust: add 3 to every BCD nibble that is 5 or more
   always_comb begin
      dabble_s = bcd_r;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_r[4*i +: 4] >= 4'd5) begin
            dabble_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
         end else begin
            dabble_s[4*i +: 4] = bcd_r[4*i +: 4];
         end
      end
   end

   // Conversion datapath and display buffer; hex values go straight into
   // bcd_r so COMMIT copies the same register for both modes
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         shift_r <= '0;
         bcd_r   <= '0;
         step_r  <= '0;
         ovf_r   <= 1'b0;
         buf_r   <= '0;
         dash_r  <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (load) begin
                  shift_r <= value_in;
                  step_r  <= '0;
                  ovf_r   <= !hex_mode && (val_ext_s >= DEC_LIMIT);
                  bcd_r   <= hex_mode ? hex_ext_s : '0;
               end
            end
            S_CONV: begin
               bcd_r   <= {dabble_s[DW-2:0], shift_r[BIN_W-1]};
               shift_r <= shift_r << 1;
               step_r  <= step_r + STEP_W'(1);
            end
            S_COMMIT: begin
               buf_r  <= bcd_r;
               dash_r <= ovf_r;
            end
            default: begin
               step_r <= '0;
            end
         endcase
      end
   end

   // Status outputs, registered from the next state so they line up with it
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_s != S_IDLE);
         done_r <= (state_r == S_COMMIT);
      end
   end

   // Scan timer: dwell SCAN_DIV cycles on a digit, then move to the next
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_r <= '0;
         idx_r <= '0;
      end else if (cnt_r == CNT_W'(SCAN_DIV - 1)) begin
         cnt_r <= '0;
         if (idx_r == IDX_W'(NUM_DIGITS - 1)) begin
            idx_r <= '0;
         end else begin
            idx_r <= idx_r + IDX_W'(1);
         end
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   // upper_zero_s[i] = digit i and every digit above it are zero
   always_comb begin
      logic run;
      run          = 1'b1;
      upper_zero_s = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run             = run & (buf_r[i] == 4'd0);
         upper_zero_s[i] = run;
      end
   end

   // Segment pattern and digit enable for the currently scanned digit
   always_comb begin
      seg_s       = 7'b0000000;
      digit_sel_s = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         digit_sel_s[i] = (idx_r == IDX_W'(i));
      end
      if (dash_r) begin
         seg_s = 7'b1000000;
      end else if (blank_en && (idx_r != '0) && upper_zero_s[idx_r]) begin
         seg_s = 7'b0000000;
      end else begin
         seg_s = seg7_enc(buf_r[idx_r]);
      end
   end

   // Output register: segments and digit enable switch on the same edge
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sv_seg_r    <= 7'b0111111;
         digit_sel_r <= NUM_DIGITS'(1);
      end else begin
         sv_seg_r    <= seg_s;
         digit_sel_r <= digit_sel_s;
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign sv_seg    = sv_seg_r;
   assign digit_sel = digit_sel_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

   localparam int ND  = 4;
   localparam int BW  = 16;
   localparam int DIV = 4;

   logic          clk;
   logic          nrst;
   logic          load;
   logic [BW-1:0] value_in;
   logic          hex_mode;
   logic          blank_en;
   logic          busy;
   logic          done;
   logic [6:0]    sv_seg;
   logic [ND-1:0] digit_sel;

   int n_tests = 0;
   int n_fail  = 0;

   seg7_scan_driver #(.NUM_DIGITS(ND), .BIN_W(BW), .SCAN_DIV(DIV)) dut (
      .clk(clk), .nrst(nrst), .load(load), .value_in(value_in),
      .hex_mode(hex_mode), .blank_en(blank_en), .busy(busy), .done(done),
      .sv_seg(sv_seg), .digit_sel(digit_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [BW-1:0]      value;
      logic               hex;
      logic               blank;
      logic [3:0][6:0]    segs;   // index 3 = most significant digit
      int                 lat;    // busy cycles
   } vec_t;

   typedef struct {
      string              name;
      logic [3:0][6:0]    segs;
   } exp_t;

   vec_t vecs[10];
   exp_t sb_q[$];

   localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011,
                          S3 = 7'b1001111, S4 = 7'b1100110, S5 = 7'b1101101,
                          S7 = 7'b0000111, S9 = 7'b1101111, SB = 7'b1111100,
                          SE = 7'b1111001, SF = 7'b1110001, SD = 7'b1000000,
                          SX = 7'b0000000;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   task automatic do_load(input logic [BW-1:0] v, input logic h, input logic b);
      @(negedge clk);
      value_in = v;
      hex_mode = h;
      blank_en = b;
      load     = 1'b1;
      @(negedge clk);
      load     = 1'b0;
   endtask

   // Count busy cycles until done, bounded
   task automatic wait_done(output int busy_n);
      int k;
      busy_n = 0;
      k = 0;
      while (!done && k < 100) begin
         if (busy) busy_n++;
         @(negedge clk);
         k++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
   endtask

   // Collect the pattern shown on each digit over one full scan
   task automatic read_display(output logic [3:0][6:0] got);
      int bad;
      bad = 0;
      got = 'x;
      for (int c = 0; c < ND * DIV; c++) begin
         @(negedge clk);
         if (!$onehot(digit_sel)) bad++;
         for (int d = 0; d < ND; d++) begin
            if (digit_sel[d]) got[d] = sv_seg;
         end
      end
      check("digit_sel_onehot", bad, 32'd0);
   endtask

   task automatic compare_display(input exp_t e);
      logic [3:0][6:0] got;
      read_display(got);
      for (int d = 0; d < ND; d++) begin
         check($sformatf("%s_digit%0d", e.name, d), {25'd0, got[d]}, {25'd0, e.segs[d]});
      end
   endtask

   initial begin
      logic [3:0] sel_seq [5];
      exp_t e;
      int bn;
      int dn;
      int bs;

      vecs[0] = '{16'd1234,  1'b0, 1'b0, {S1, S2, S3, S4}, 17};
      vecs[1] = '{16'd7,     1'b0, 1'b1, {SX, SX, SX, S7}, 17};
      vecs[2] = '{16'd7,     1'b0, 1'b0, {S0, S0, S0, S7}, 17};
      vecs[3] = '{16'd0,     1'b0, 1'b1, {SX, SX, SX, S0}, 17};
      vecs[4] = '{16'hBEEF,  1'b1, 1'b0, {SB, SE, SE, SF}, 1};
      vecs[5] = '{16'd10000, 1'b0, 1'b1, {SD, SD, SD, SD}, 17};
      vecs[6] = '{16'd9999,  1'b0, 1'b1, {S9, S9, S9, S9}, 17};
      vecs[7] = '{16'h0050,  1'b1, 1'b1, {SX, SX, S5, S0}, 1};
      vecs[8] = '{16'd305,   1'b0, 1'b1, {SX, S3, S0, S5}, 17};
      vecs[9] = '{16'd65535, 1'b0, 1'b0, {SD, SD, SD, SD}, 17};

      sel_seq[0] = 4'b0001; sel_seq[1] = 4'b0010; sel_seq[2] = 4'b0100;
      sel_seq[3] = 4'b1000; sel_seq[4] = 4'b0001;

      // Reset state
      nrst = 1'b0; load = 1'b0; value_in = '0; hex_mode = 1'b0; blank_en = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_digit_sel", {28'd0, digit_sel}, 32'd1);
      check("rst_sv_seg", {25'd0, sv_seg}, {25'd0, S0});

      // Scan sequence after release
      nrst = 1'b1;
      @(negedge clk);
      check("scan_step0", {28'd0, digit_sel}, {28'd0, sel_seq[0]});
      for (int s = 1; s < 5; s++) begin
         repeat (DIV) @(negedge clk);
         check($sformatf("scan_step%0d", s), {28'd0, digit_sel}, {28'd0, sel_seq[s]});
      end

      // Table-driven vectors through the scoreboard
      for (int i = 0; i < 10; i++) begin
         do_load(vecs[i].value, vecs[i].hex, vecs[i].blank);
         sb_q.push_back('{$sformatf("vec%0d", i), vecs[i].segs});
         wait_done(bn);
         check($sformatf("vec%0d_busy_cycles", i), bn, vecs[i].lat);
         @(negedge clk);
         check($sformatf("vec%0d_done_width", i), {31'd0, done}, 32'd0);
         e = sb_q.pop_front();
         compare_display(e);
      end

      // Handshake: load while busy is dropped, load on the done cycle is taken
      do_load(16'd1234, 1'b0, 1'b0);
      sb_q.push_back('{"hs_first", {S1, S2, S3, S4}});
      value_in = 16'd5678;
      load     = 1'b1;
      repeat (3) @(negedge clk);
      load     = 1'b0;
      wait_done(bn);
      value_in = 16'd42;
      hex_mode = 1'b0;
      blank_en = 1'b1;
      load     = 1'b1;
      @(negedge clk);
      load     = 1'b0;
      check("hs_done_cycle_load_accepted", {31'd0, busy}, 32'd1);
      check("hs_done_width", {31'd0, done}, 32'd0);
      e = sb_q.pop_front();
      blank_en = 1'b0;
      compare_display(e);   // still 1234 while 42 converts
      sb_q.push_back('{"hs_second", {SX, SX, S4, S2}});
      blank_en = 1'b1;
      wait_done(bn);
      e = sb_q.pop_front();
      compare_display(e);

      // Asynchronous reset in the middle of a conversion
      do_load(16'd1234, 1'b0, 1'b0);
      repeat (7) @(negedge clk);
      #2 nrst = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_sv_seg", {25'd0, sv_seg}, {25'd0, S0});
      check("arst_digit_sel", {28'd0, digit_sel}, 32'd1);
      @(negedge clk);
      nrst = 1'b1;
      dn = 0;
      bs = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (done) dn++;
         if (busy) bs++;
      end
      check("arst_no_done", dn, 32'd0);
      check("arst_idle", bs, 32'd0);
      compare_display('{"arst_zero", {S0, S0, S0, S0}});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
